// File: rtl/md_issue_ctrl_if.sv
// Command/response bundle between the E-stage issue controller and the HI/LO multiply-divide unit.
interface md_issue_ctrl_if;
  logic [3:0]  md_hilotype;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_busy;
  logic [31:0] md_hilo;

  modport master (
    output md_hilotype,
    output md_a,
    output md_b,
    input  md_busy,
    input  md_hilo
  );

  modport slave (
    input  md_hilotype,
    input  md_a,
    input  md_b,
    output md_busy,
    output md_hilo
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the HI/LO multiply-divide unit: decodes, issues, and stalls dependents.
// Optional macro MD_LAT_CHECK_EN: sticky lat_err cross-check of the internal counter vs md_busy.
module md_issue_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req,
  input  logic                  e_valid,
  input  logic [3:0]            e_hilotype,
  input  logic [31:0]           e_rs,
  input  logic [31:0]           e_rt,
  md_issue_ctrl_if.master       md,
  output logic                  stall,
  output logic [31:0]           e_md_result,
  output logic                  lat_err
);

  // HI/LO op encoding shared with the decoder; 0 means no HI/LO op.
  localparam logic [3:0] HiloMult  = 4'd1;
  localparam logic [3:0] HiloMultu = 4'd2;
  localparam logic [3:0] HiloDiv   = 4'd3;
  localparam logic [3:0] HiloDivu  = 4'd4;
  localparam logic [3:0] HiloMadd  = 4'd5;
  localparam logic [3:0] HiloMaddu = 4'd6;
  localparam logic [3:0] HiloMsub  = 4'd7;
  localparam logic [3:0] HiloMsubu = 4'd8;
  localparam logic [3:0] HiloMthi  = 4'd9;
  localparam logic [3:0] HiloMtlo  = 4'd10;
  localparam logic [3:0] HiloMfhi  = 4'd11;
  localparam logic [3:0] HiloMflo  = 4'd12;

  typedef enum logic [1:0] {ClsNone, ClsStart, ClsMove, ClsRead} cls_e;
  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cls_e             cls;
  logic             is_div;
  logic             hazard;
  logic             issue;

  always_comb begin
    cls    = ClsNone;
    is_div = 1'b0;
    case (e_hilotype)
      HiloMult, HiloMultu, HiloMadd, HiloMaddu, HiloMsub, HiloMsubu: cls = ClsStart;
      HiloDiv, HiloDivu: begin
        cls    = ClsStart;
        is_div = 1'b1;
      end
      HiloMthi, HiloMtlo: cls = ClsMove;
      HiloMfhi, HiloMflo: cls = ClsRead;
      default:            cls = ClsNone;
    endcase
  end

`ifdef MD_LAT_CHECK_EN
  assign hazard = (state_q == StRun);
`else
  assign hazard = (state_q == StRun) | md.md_busy;
`endif

  // Req wins over both issue and stall so the flush can drain the E stage.
  assign issue = e_valid & (cls != ClsNone) & ~hazard & ~Req;
  assign stall = e_valid & (cls != ClsNone) & hazard & ~Req;

  always_comb begin
    md.md_hilotype = issue ? e_hilotype : 4'd0;
    md.md_a        = issue ? e_rs : 32'd0;
    md.md_b        = issue ? e_rt : 32'd0;
    e_md_result    = (issue && cls == ClsRead) ? md.md_hilo : 32'd0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (issue && cls == ClsStart) begin
          state_d = StRun;
          cnt_d   = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end
      end
      StRun: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        // cnt == 0 in RUN is illegal; fall back to IDLE rather than hang.
        if (cnt_q <= CNT_W'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MD_LAT_CHECK_EN
  logic issue_q;
  logic lat_err_q;
  logic early, late;

  assign early = (state_q == StRun) & ~md.md_busy & (cnt_q > CNT_W'(1));
  assign late  = (state_q == StIdle) & md.md_busy & ~issue_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_q   <= 1'b0;
      lat_err_q <= 1'b0;
    end else begin
      issue_q <= issue;
      if (early || late) lat_err_q <= 1'b1;
    end
  end

  assign lat_err = lat_err_q;
`else
  assign lat_err = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a behavioural multiply-divide unit model behind the interface.
module tb_md_issue_ctrl;

  localparam logic [3:0] H_NONE  = 4'd0;
  localparam logic [3:0] H_MULT  = 4'd1;
  localparam logic [3:0] H_MULTU = 4'd2;
  localparam logic [3:0] H_DIV   = 4'd3;
  localparam logic [3:0] H_DIVU  = 4'd4;
  localparam logic [3:0] H_MADD  = 4'd5;
  localparam logic [3:0] H_MADDU = 4'd6;
  localparam logic [3:0] H_MSUB  = 4'd7;
  localparam logic [3:0] H_MSUBU = 4'd8;
  localparam logic [3:0] H_MTHI  = 4'd9;
  localparam logic [3:0] H_MTLO  = 4'd10;
  localparam logic [3:0] H_MFHI  = 4'd11;
  localparam logic [3:0] H_MFLO  = 4'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic        e_valid;
  logic [3:0]  e_hilotype;
  logic [31:0] e_rs, e_rt;
  logic        stall;
  logic [31:0] e_md_result;
  logic        lat_err;

  int n_checks = 0;
  int n_fail   = 0;

  md_issue_ctrl_if mif ();

  md_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .Req         (Req),
    .e_valid     (e_valid),
    .e_hilotype  (e_hilotype),
    .e_rs        (e_rs),
    .e_rt        (e_rt),
    .md          (mif),
    .stall       (stall),
    .e_md_result (e_md_result),
    .lat_err     (lat_err)
  );

  always #5 clk = ~clk;

  // Behavioural unit: START ops stay busy for their latency, then update HI/LO on the last edge.
  logic [31:0]        hi_r, lo_r;
  logic [63:0]        pend;
  logic               busy_m;
  int                 cnt_m;
  logic signed [63:0] sa, sb;
  logic [63:0]        ua, ub;

  assign sa = {{32{mif.md_a[31]}}, mif.md_a};
  assign sb = {{32{mif.md_b[31]}}, mif.md_b};
  assign ua = {32'd0, mif.md_a};
  assign ub = {32'd0, mif.md_b};
  assign mif.md_busy = busy_m;
  assign mif.md_hilo = (mif.md_hilotype == H_MFHI) ? hi_r : lo_r;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_m <= 1'b0;
      cnt_m  <= 0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
      pend   <= 64'd0;
    end else begin
      if (busy_m) begin
        cnt_m <= cnt_m - 1;
        if (cnt_m == 1) begin
          {hi_r, lo_r} <= pend;
          busy_m       <= 1'b0;
        end
      end
      case (mif.md_hilotype)
        H_MULT:  begin pend <= sa * sb; busy_m <= 1'b1; cnt_m <= 5; end
        H_MULTU: begin pend <= ua * ub; busy_m <= 1'b1; cnt_m <= 5; end
        H_MADD:  begin pend <= {hi_r, lo_r} + sa * sb; busy_m <= 1'b1; cnt_m <= 5; end
        H_MADDU: begin pend <= {hi_r, lo_r} + ua * ub; busy_m <= 1'b1; cnt_m <= 5; end
        H_MSUB:  begin pend <= {hi_r, lo_r} - sa * sb; busy_m <= 1'b1; cnt_m <= 5; end
        H_MSUBU: begin pend <= {hi_r, lo_r} - ua * ub; busy_m <= 1'b1; cnt_m <= 5; end
        H_DIV: begin
          pend   <= {32'($signed(mif.md_a) % $signed(mif.md_b)),
                     32'($signed(mif.md_a) / $signed(mif.md_b))};
          busy_m <= 1'b1;
          cnt_m  <= 10;
        end
        H_DIVU:  begin pend <= {mif.md_a % mif.md_b, mif.md_a / mif.md_b}; busy_m <= 1'b1; cnt_m <= 10; end
        H_MTHI:  hi_r <= mif.md_a;
        H_MTLO:  lo_r <= mif.md_a;
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds an op in E until it issues (bounded), returning stall count and the issue-cycle outputs.
  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output int stalls, output logic [3:0] cmd, output logic [31:0] a,
                        output logic [31:0] b, output logic [31:0] res);
    e_valid = 1'b1; e_hilotype = op; e_rs = rs; e_rt = rt;
    stalls = 0;
    #1;
    while (stall && stalls < 50) begin
      stalls++;
      tick();
    end
    cmd = mif.md_hilotype; a = mif.md_a; b = mif.md_b; res = e_md_result;
    tick();
    e_valid = 1'b0; e_hilotype = H_NONE; e_rs = 32'd0; e_rt = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; Req = 1'b0; e_valid = 1'b0; e_hilotype = H_NONE; e_rs = 32'd0; e_rt = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (mif.md_hilotype !== 4'd0) begin n_fail++; $display("FAIL reset_cmd: got %h want 0", mif.md_hilotype); end
    n_checks++; if (mif.md_a !== 32'd0) begin n_fail++; $display("FAIL reset_a: got %h want 0", mif.md_a); end
    n_checks++; if (mif.md_b !== 32'd0) begin n_fail++; $display("FAIL reset_b: got %h want 0", mif.md_b); end
    n_checks++; if (e_md_result !== 32'd0) begin n_fail++; $display("FAIL reset_res: got %h want 0", e_md_result); end
    n_checks++; if (lat_err !== 1'b0) begin n_fail++; $display("FAIL reset_laterr: got %b want 0", lat_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    int st; logic [3:0] c; logic [31:0] a, b, r;
    run_op(H_MULT, 32'd3, 32'hFFFF_FFFE, st, c, a, b, r);
    n_checks++; if (st !== 0) begin n_fail++; $display("FAIL mult_nostall: got %0d want 0", st); end
    n_checks++; if (c !== H_MULT) begin n_fail++; $display("FAIL mult_cmd: got %h want %h", c, H_MULT); end
    n_checks++; if (a !== 32'd3) begin n_fail++; $display("FAIL mult_a: got %h want 3", a); end
    n_checks++; if (b !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mult_b: got %h want fffffffe", b); end
    n_checks++; if (mif.md_hilotype !== 4'd0) begin n_fail++; $display("FAIL mult_one_cycle: got %h want 0", mif.md_hilotype); end
    run_op(H_MFLO, 32'd0, 32'd0, st, c, a, b, r);
    n_checks++; if (st !== 5) begin n_fail++; $display("FAIL mult_mflo_stalls: got %0d want 5", st); end
    n_checks++; if (r !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_mflo_res: got %h want fffffffa", r); end
    run_op(H_MFHI, 32'd0, 32'd0, st, c, a, b, r);
    n_checks++; if (st !== 0) begin n_fail++; $display("FAIL mult_mfhi_stalls: got %0d want 0", st); end
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_mfhi_res: got %h want ffffffff", r); end
  endtask

  task automatic test_divu();
    int st; logic [3:0] c; logic [31:0] a, b, r;
    run_op(H_DIVU, 32'd100, 32'd7, st, c, a, b, r);
    n_checks++; if (c !== H_DIVU) begin n_fail++; $display("FAIL divu_cmd: got %h want %h", c, H_DIVU); end
    e_valid = 1'b1; e_hilotype = H_MFHI;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL divu_stall_on: got %b want 1", stall); end
    n_checks++; if (mif.md_hilotype !== 4'd0) begin n_fail++; $display("FAIL divu_stall_cmd: got %h want 0", mif.md_hilotype); end
    n_checks++; if (e_md_result !== 32'd0) begin n_fail++; $display("FAIL divu_stall_res: got %h want 0", e_md_result); end
    run_op(H_MFHI, 32'd0, 32'd0, st, c, a, b, r);
    n_checks++; if (st !== 10) begin n_fail++; $display("FAIL divu_mfhi_stalls: got %0d want 10", st); end
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL divu_mfhi_res: got %h want 2", r); end
    // 53/8: quotient 6, remainder 5; an addu sits between issue and mfhi.
    run_op(H_DIVU, 32'd53, 32'd8, st, c, a, b, r);
    e_valid = 1'b1; e_hilotype = H_NONE;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL addu_nostall: got %b want 0", stall); end
    n_checks++; if (mif.md_hilotype !== 4'd0) begin n_fail++; $display("FAIL addu_cmd: got %h want 0", mif.md_hilotype); end
    tick();
    run_op(H_MFHI, 32'd0, 32'd0, st, c, a, b, r);
    n_checks++; if (st !== 9) begin n_fail++; $display("FAIL addu_mfhi_stalls: got %0d want 9", st); end
    n_checks++; if (r !== 32'd5) begin n_fail++; $display("FAIL addu_mfhi_res: got %h want 5", r); end
  endtask

  task automatic test_req_flush();
    int st; logic [3:0] c; logic [31:0] a, b, r;
    e_valid = 1'b1; e_hilotype = H_DIV; e_rs = 32'd9; e_rt = 32'd3; Req = 1'b1;
    #1;
    n_checks++; if (mif.md_hilotype !== 4'd0) begin n_fail++; $display("FAIL flush_cmd: got %h want 0", mif.md_hilotype); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall); end
    tick();
    Req = 1'b0; e_valid = 1'b0; e_hilotype = H_NONE;
    run_op(H_MFLO, 32'd0, 32'd0, st, c, a, b, r);
    n_checks++; if (st !== 0) begin n_fail++; $display("FAIL flush_mflo_stalls: got %0d want 0", st); end
    n_checks++; if (r !== 32'd6) begin n_fail++; $display("FAIL flush_mflo_res: got %h want 6", r); end
  endtask

  task automatic test_req_during_run();
    int st; logic [3:0] c; logic [31:0] a, b, r;
    run_op(H_MULT, 32'd6, 32'd7, st, c, a, b, r);
    e_valid = 1'b1; e_hilotype = H_MFLO;
    for (int i = 0; i < 5; i++) begin
      Req = (i == 2);
      #1;
      n_checks++;
      if (stall !== (i != 2)) begin n_fail++; $display("FAIL run_req_stall[%0d]: got %b want %b", i, stall, (i != 2)); end
      tick();
    end
    Req = 1'b0;
    run_op(H_MFLO, 32'd0, 32'd0, st, c, a, b, r);
    n_checks++; if (st !== 0) begin n_fail++; $display("FAIL run_req_mflo_stalls: got %0d want 0", st); end
    n_checks++; if (r !== 32'd42) begin n_fail++; $display("FAIL run_req_mflo_res: got %h want 2a", r); end
    run_op(H_MULT, 32'h0001_0000, 32'h0001_0000, st, c, a, b, r);
    n_checks++; if (st !== 0) begin n_fail++; $display("FAIL run_req_newmult_stalls: got %0d want 0", st); end
    n_checks++; if (c !== H_MULT) begin n_fail++; $display("FAIL run_req_newmult_cmd: got %h want %h", c, H_MULT); end
  endtask

  task automatic test_back_to_back();
    int st; logic [3:0] c; logic [31:0] a, b, r;
    run_op(H_MULTU, 32'h8000_0000, 32'd4, st, c, a, b, r);
    n_checks++; if (st !== 5) begin n_fail++; $display("FAIL b2b_multu_stalls: got %0d want 5", st); end
    n_checks++; if (c !== H_MULTU) begin n_fail++; $display("FAIL b2b_multu_cmd: got %h want %h", c, H_MULTU); end
    run_op(H_MFHI, 32'd0, 32'd0, st, c, a, b, r);
    n_checks++; if (st !== 5) begin n_fail++; $display("FAIL b2b_mfhi_stalls: got %0d want 5", st); end
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL b2b_mfhi_res: got %h want 2", r); end
  endtask

  task automatic test_move();
    int st; logic [3:0] c; logic [31:0] a, b, r;
    run_op(H_MTHI, 32'h0000_1234, 32'd0, st, c, a, b, r);
    n_checks++; if (st !== 0) begin n_fail++; $display("FAIL mthi_stalls: got %0d want 0", st); end
    n_checks++; if (c !== H_MTHI || a !== 32'h1234) begin n_fail++; $display("FAIL mthi_cmd: got %h/%h want %h/1234", c, a, H_MTHI); end
    run_op(H_MFHI, 32'd0, 32'd0, st, c, a, b, r);
    n_checks++; if (st !== 0) begin n_fail++; $display("FAIL mthi_mfhi_stalls: got %0d want 0", st); end
    n_checks++; if (r !== 32'h1234) begin n_fail++; $display("FAIL mthi_mfhi_res: got %h want 1234", r); end
  endtask

  task automatic test_reset_mid_run();
    int st; logic [3:0] c; logic [31:0] a, b, r;
    run_op(H_DIV, 32'd100, 32'd5, st, c, a, b, r);
    e_valid = 1'b1; e_hilotype = H_MFLO;
    tick();
    tick();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_run_stall: got %b want 1", stall); end
    reset = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall_drop: got %b want 0", stall); end
    tick();
    e_hilotype = H_MULT; e_rs = 32'd2; e_rt = 32'd3;
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (mif.md_hilotype !== H_MULT) begin n_fail++; $display("FAIL rst_reissue_cmd: got %h want %h", mif.md_hilotype, H_MULT); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_reissue_stall: got %b want 0", stall); end
    tick();
    e_valid = 1'b0; e_hilotype = H_NONE; e_rs = 32'd0; e_rt = 32'd0;
    run_op(H_MFLO, 32'd0, 32'd0, st, c, a, b, r);
    n_checks++; if (st !== 5) begin n_fail++; $display("FAIL rst_mflo_stalls: got %0d want 5", st); end
    n_checks++; if (r !== 32'd6) begin n_fail++; $display("FAIL rst_mflo_res: got %h want 6", r); end
    n_checks++; if (lat_err !== 1'b0) begin n_fail++; $display("FAIL final_laterr: got %b want 0", lat_err); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu();
    test_req_flush();
    test_req_during_run();
    test_back_to_back();
    test_move();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
